// File: rtl/data_memory_arbiter_if.sv
// rtl/data_memory_arbiter_if.sv - requester and data_memory bus bundle for data_memory_arbiter
// The memory byte pin is named mem_byte because byte is a reserved word.
interface data_memory_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic          byte0;
  logic          byte1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          MemRead;
  logic          MemWrite;
  logic          mem_byte;

  modport master (
    output req0, req1, we0, we1, byte0, byte1, addr0, addr1, wdata0, wdata1, read_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  address, write_data, MemRead, MemWrite, mem_byte
  );

  modport slave (
    input  req0, req1, we0, we1, byte0, byte1, addr0, addr1, wdata0, wdata1, read_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output address, write_data, MemRead, MemWrite, mem_byte
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port data_memory arbiter, IDLE/ACCESS/RESP sequencing
// Round-robin by default; ARB_CPU_PRIORITY_EN selects port-0 priority with a port-1 starvation bound.
module data_memory_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
`ifdef ARB_CPU_PRIORITY_EN
  , parameter int MAX_WAIT = 4
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  data_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          owner;
  logic          win;
  logic          pick1;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;
  logic          sel_byte;

`ifdef ARB_CPU_PRIORITY_EN
  localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
  logic [WAIT_W-1:0] wait_cnt;

  // Port 0 wins contention unless port 1 has already lost MAX_WAIT times in a row.
  always_comb begin
    pick1 = bus.req1;
    if (bus.req0 && bus.req1) pick1 = (wait_cnt == WAIT_W'(MAX_WAIT));
  end
`else
  logic rr_last;

  always_comb begin
    pick1 = bus.req1;
    if (bus.req0 && bus.req1) pick1 = ~rr_last;
  end
`endif

  assign win = bus.req0 | bus.req1;

  always_comb begin
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    sel_we    = bus.we0;
    sel_byte  = bus.byte0;
    if (pick1) begin
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
      sel_we    = bus.we1;
      sel_byte  = bus.byte1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      owner          <= 1'b0;
      bus.gnt0       <= 1'b0;
      bus.gnt1       <= 1'b0;
      bus.rvalid0    <= 1'b0;
      bus.rvalid1    <= 1'b0;
      bus.rdata0     <= '0;
      bus.rdata1     <= '0;
      bus.address    <= '0;
      bus.write_data <= '0;
      bus.MemRead    <= 1'b0;
      bus.MemWrite   <= 1'b0;
      bus.mem_byte   <= 1'b0;
`ifdef ARB_CPU_PRIORITY_EN
      wait_cnt       <= '0;
`else
      rr_last        <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE, RESP: begin
          bus.rvalid0 <= 1'b0;
          bus.rvalid1 <= 1'b0;
          if (win) begin
            owner          <= pick1;
            bus.address    <= sel_addr;
            bus.write_data <= sel_wdata;
            bus.mem_byte   <= sel_byte;
            bus.MemWrite   <= sel_we;
            bus.MemRead    <= ~sel_we;
            bus.gnt0       <= ~pick1;
            bus.gnt1       <= pick1;
            state          <= ACCESS;
`ifdef ARB_CPU_PRIORITY_EN
            if (!bus.req1 || pick1) wait_cnt <= '0;
            else                    wait_cnt <= wait_cnt + 1'b1;
`else
            if (bus.req0 && bus.req1) rr_last <= pick1;
`endif
          end else begin
            state <= IDLE;
`ifdef ARB_CPU_PRIORITY_EN
            wait_cnt <= '0;
`endif
          end
        end
        ACCESS: begin
          bus.gnt0     <= 1'b0;
          bus.gnt1     <= 1'b0;
          bus.MemRead  <= 1'b0;
          bus.MemWrite <= 1'b0;
          // A write leaves the owner's rdata untouched.
          if (bus.MemRead) begin
            if (owner) bus.rdata1 <= bus.read_data;
            else       bus.rdata0 <= bus.read_data;
          end
          bus.rvalid0 <= ~owner;
          bus.rvalid1 <= owner;
          state       <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - scoreboard bench for data_memory_arbiter
module tb_data_memory_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_arbiter_if #(.AW(32), .DW(32)) bus ();
  data_memory_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        port;
    logic        we;
    logic        bt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t exp_gnt[$];
  txn_t exp_resp[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_gnt_cyc = -1;
  bit   spacing_chk = 1'b0;

  // Word-addressed data_memory model: combinational read, write at the clock edge.
  logic        init_done = 1'b0;
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (!init_done) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'hC0DE0000 | 32'(k);
      mem[4]    <= 32'hDEADBEEF;
      init_done <= 1'b1;
    end else if (bus.MemWrite) begin
      if (bus.mem_byte) mem[bus.address[9:2]][7:0] <= bus.write_data[7:0];
      else              mem[bus.address[9:2]]      <= bus.write_data;
    end
  end
  assign bus.read_data = mem[bus.address[9:2]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic p, input logic w, input logic b,
                              input logic [31:0] a, input logic [31:0] d, input logic [31:0] r);
    txn_t t;
    t.port = p; t.we = w; t.bt = b; t.addr = a; t.wdata = d; t.rdata = r;
    return t;
  endfunction

  always @(negedge clk) begin : monitor
    txn_t t;
    chk("gnt_both", 32'(bus.gnt0 & bus.gnt1), 32'd0);
    chk("rvalid_both", 32'(bus.rvalid0 & bus.rvalid1), 32'd0);
    chk("memrd_memwr_both", 32'(bus.MemRead & bus.MemWrite), 32'd0);
    if (bus.gnt0 || bus.gnt1) begin
      if (exp_gnt.size() == 0) chk("unexpected_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
      else begin
        t = exp_gnt.pop_front();
        chk("gnt_port", 32'(bus.gnt1), 32'(t.port));
        chk("address", bus.address, t.addr);
        chk("MemRead", 32'(bus.MemRead), 32'(!t.we));
        chk("MemWrite", 32'(bus.MemWrite), 32'(t.we));
        chk("byte", 32'(bus.mem_byte), 32'(t.bt));
        if (t.we) chk("write_data", bus.write_data, t.wdata);
      end
      if (spacing_chk) begin
        if (last_gnt_cyc >= 0) chk("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'd2);
        last_gnt_cyc = cyc;
      end
    end
    if (bus.rvalid0 || bus.rvalid1) begin
      if (exp_resp.size() == 0) chk("unexpected_rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'd0);
      else begin
        t = exp_resp.pop_front();
        chk("rvalid_port", 32'(bus.rvalid1), 32'(t.port));
        chk("rdata", t.port ? bus.rdata1 : bus.rdata0, t.rdata);
      end
    end
  end

  task automatic drive(input bit p, input logic r, input logic w, input logic b,
                       input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      bus.req1 = r; bus.we1 = w; bus.byte1 = b; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = r; bus.we0 = w; bus.byte0 = b; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic wait_gnt(input bit p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      ok = p ? bus.gnt1 : bus.gnt0;
    end
    if (!ok) chk(p ? "gnt1_timeout" : "gnt0_timeout", 32'(ok), 32'd1);
  endtask

  task automatic access(input bit p, input logic w, input logic b,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rexp);
    bit ok;
    exp_gnt.push_back(mk(p, w, b, a, d, rexp));
    exp_resp.push_back(mk(p, w, b, a, d, rexp));
    drive(p, 1'b1, w, b, a, d);
    wait_gnt(p, ok);
    drive(p, 1'b0, w, b, a, d);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic stream(input bit p, input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      drive(p, 1'b1, 1'b0, 1'b0, (p ? 32'h80 : 32'h40) + 32'(4 * i), 32'd0);
      wait_gnt(p, ok);
      if (!ok) break;
    end
    drive(p, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int order[$];
    int n0, n1, i0, i1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) begin @(posedge clk); #1; end

    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("rst_MemRead", 32'(bus.MemRead), 32'd0);
    chk("rst_MemWrite", 32'(bus.MemWrite), 32'd0);
    chk("rst_byte", 32'(bus.mem_byte), 32'd0);
    chk("rst_address", bus.address, 32'd0);
    chk("rst_write_data", bus.write_data, 32'd0);
    chk("rst_rdata0", bus.rdata0, 32'd0);
    chk("rst_rdata1", bus.rdata1, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read on port 0, then write/read and byte write/read on port 1.
    access(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF);
    access(1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678, 32'h00000000);
    access(1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 32'h12345678);
    access(1'b1, 1'b1, 1'b1, 32'h20, 32'h000000AB, 32'h12345678);
    access(1'b1, 1'b0, 1'b1, 32'h20, 32'd0, 32'h123456AB);

    // Continuous contention; order lists the hand-derived grant sequence.
`ifdef ARB_CPU_PRIORITY_EN
    order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    n0 = 8; n1 = 2;
`else
    order = '{0, 1, 0, 1};
    n0 = 2; n1 = 2;
`endif
    i0 = 0; i1 = 0;
    foreach (order[k]) begin
      if (order[k] == 0) begin
        exp_gnt.push_back(mk(1'b0, 1'b0, 1'b0, 32'h40 + 32'(4 * i0), 32'd0, 32'hC0DE0010 + 32'(i0)));
        exp_resp.push_back(mk(1'b0, 1'b0, 1'b0, 32'h40 + 32'(4 * i0), 32'd0, 32'hC0DE0010 + 32'(i0)));
        i0++;
      end else begin
        exp_gnt.push_back(mk(1'b1, 1'b0, 1'b0, 32'h80 + 32'(4 * i1), 32'd0, 32'hC0DE0020 + 32'(i1)));
        exp_resp.push_back(mk(1'b1, 1'b0, 1'b0, 32'h80 + 32'(4 * i1), 32'd0, 32'hC0DE0020 + 32'(i1)));
        i1++;
      end
    end
    last_gnt_cyc = -1;
    spacing_chk  = 1'b1;
    fork
      stream(1'b0, n0);
      stream(1'b1, n1);
    join
    repeat (3) begin @(posedge clk); #1; end
    spacing_chk = 1'b0;

    // Reset during the ACCESS cycle of a read: no rvalid may follow.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
    wait_gnt(1'b0, ok);
    chk("midrst_MemRead_before", 32'(bus.MemRead), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("midrst_MemRead", 32'(bus.MemRead), 32'd0);
    chk("midrst_address", bus.address, 32'd0);
    chk("midrst_rdata0", bus.rdata0, 32'd0);
    chk("midrst_rdata1", bus.rdata1, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    chk("midrst_rvalid0", 32'(bus.rvalid0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_rvalid0", 32'(bus.rvalid0), 32'd0);
    access(1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 32'h123456AB);

    // Port 1 withdraws during port 0's ACCESS; a new req0 in RESP is granted next cycle.
    exp_gnt.push_back(mk(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF));
    exp_resp.push_back(mk(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'd0);
    wait_gnt(1'b0, ok);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'd0);
    @(posedge clk); #1;
    chk("wd_rvalid0", 32'(bus.rvalid0), 32'd1);
    exp_gnt.push_back(mk(1'b0, 1'b0, 1'b0, 32'h44, 32'd0, 32'hC0DE0011));
    exp_resp.push_back(mk(1'b0, 1'b0, 1'b0, 32'h44, 32'd0, 32'hC0DE0011));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'd0);
    @(posedge clk); #1;
    chk("b2b_gnt0", 32'(bus.gnt0), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'd0);
    repeat (4) begin @(posedge clk); #1; end

    chk("gnt_queue_left", 32'(exp_gnt.size()), 32'd0);
    chk("resp_queue_left", 32'(exp_resp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
